// File: rtl/cmp_lgez_serial.sv
// Digit-serial MSB-first magnitude comparator returning the {rx,ry} less/greater/equal-zero code.
// Latency 1..p_NDIG cycles after accept; result held in DONE until i_ready, no accept while busy.
module cmp_lgez_serial #(
  parameter int p_WIDTH = 16,
  parameter int p_DIGIT = 4,
  localparam int p_NDIG = p_WIDTH / p_DIGIT,
  localparam int p_CW   = $clog2(p_NDIG + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic               i_signed,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_rx,
  output logic               o_ry,
  output logic [p_CW-1:0]    o_cycles
);

  localparam int p_KW = (p_NDIG > 1) ? $clog2(p_NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [p_WIDTH-1:0] x_q;
  logic [p_WIDTH-1:0] y_q;
  logic               sgn_q;
  logic [p_KW-1:0]    k;
  logic               nz;
  logic [p_CW-1:0]    cnt;

  logic [p_DIGIT-1:0] x_dig;
  logic [p_DIGIT-1:0] y_dig;
  logic [p_DIGIT-1:0] x_cmp;
  logic [p_DIGIT-1:0] y_cmp;
  logic               first_dig;
  logic               last_dig;
  logic               nz_now;

  always_comb begin
    x_dig = '0;
    y_dig = '0;
    for (int i = 0; i < p_NDIG; i++) begin
      if (k == p_KW'(i)) begin
        x_dig = x_q[p_WIDTH-1-i*p_DIGIT -: p_DIGIT];
        y_dig = y_q[p_WIDTH-1-i*p_DIGIT -: p_DIGIT];
      end
    end
    first_dig = (k == '0);
    last_dig  = (k == p_KW'(p_NDIG - 1));
    // Flipping both sign bits maps two's complement onto offset binary, so an unsigned compare works.
    x_cmp = x_dig;
    y_cmp = y_dig;
    if (sgn_q && first_dig) begin
      x_cmp[p_DIGIT-1] = ~x_dig[p_DIGIT-1];
      y_cmp[p_DIGIT-1] = ~y_dig[p_DIGIT-1];
    end
    nz_now = nz | (|x_dig);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
      k     <= '0;
      nz    <= 1'b0;
      cnt   <= '0;
      o_rx  <= 1'b0;
      o_ry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            x_q   <= i_x;
            y_q   <= i_y;
            sgn_q <= i_signed;
            k     <= '0;
            nz    <= 1'b0;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt + p_CW'(1);
          nz  <= nz_now;
          if (x_cmp < y_cmp) begin
            o_rx  <= 1'b0;
            o_ry  <= 1'b1;
            state <= DONE;
          end else if (x_cmp > y_cmp) begin
            o_rx  <= 1'b1;
            o_ry  <= 1'b0;
            state <= DONE;
          end else if (last_dig) begin
            // Equal operands: only X's nonzero history separates 00 from 11.
            o_rx  <= nz_now;
            o_ry  <= nz_now;
            state <= DONE;
          end else begin
            k <= k + p_KW'(1);
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_cycles = cnt;

endmodule
